writeback_stage: RTL and testbench

- Final (writeback) stage of the 5-stage 16-bit CPU pipeline.
- Comprises the MEM/WB pipeline register followed by a 2:1 writeback-select mux.
- Captures memory read data, ALU result, writeback-select and the ni flag from the memory stage, then presents the selected writeback word to the register file one cycle later.

---
 rtl/writeback_stage.sv | 73 +++++++
 tb/tb_writeback_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register followed by the writeback-select mux.
// Optional build macro WB_BUBBLE_ZERO_EN forces wb_data to zero for bubble slots (ni_out=0).
module writeback_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             wbs_in,
  input  logic [WIDTH-1:0] memData_in,
  input  logic [WIDTH-1:0] ALUresult_in,
  input  logic             ni_in,
  output logic             wbs_out,
  output logic [WIDTH-1:0] memData_out,
  output logic [WIDTH-1:0] ALUresult_out,
  output logic             ni_out,
  output logic [WIDTH-1:0] wb_data
);

  logic             wbs_q, wbs_d;
  logic [WIDTH-1:0] memData_q, memData_d;
  logic [WIDTH-1:0] ALUresult_q, ALUresult_d;
  logic             ni_q, ni_d;
  logic [WIDTH-1:0] wbMux;

  // Flush beats stall; a flush loads the same all-zero bubble that reset produces.
  always_comb begin
    wbs_d       = wbs_q;
    memData_d   = memData_q;
    ALUresult_d = ALUresult_q;
    ni_d        = ni_q;
    if (flush_in) begin
      wbs_d       = 1'b0;
      memData_d   = '0;
      ALUresult_d = '0;
      ni_d        = 1'b0;
    end else if (!stall_in) begin
      wbs_d       = wbs_in;
      memData_d   = memData_in;
      ALUresult_d = ALUresult_in;
      ni_d        = ni_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_q       <= 1'b0;
      memData_q   <= '0;
      ALUresult_q <= '0;
      ni_q        <= 1'b0;
    end else begin
      wbs_q       <= wbs_d;
      memData_q   <= memData_d;
      ALUresult_q <= ALUresult_d;
      ni_q        <= ni_d;
    end
  end

  assign wbs_out       = wbs_q;
  assign memData_out   = memData_q;
  assign ALUresult_out = ALUresult_q;
  assign ni_out        = ni_q;

  assign wbMux = wbs_q ? memData_q : ALUresult_q;

`ifdef WB_BUBBLE_ZERO_EN
  assign wb_data = ni_q ? wbMux : '0;
`else
  assign wb_data = wbMux;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a reference model pushes the expected
// outputs per edge, and each scenario task pops and compares after the edge.
module tb_writeback_stage;

  localparam int WIDTH = 16;
  localparam int VW    = 2 + 3 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n, stall_in, flush_in, wbs_in, ni_in;
  logic [WIDTH-1:0] memData_in, ALUresult_in;
  logic             wbs_out, ni_out;
  logic [WIDTH-1:0] memData_out, ALUresult_out, wb_data;

  logic             mWbs, mNi;
  logic [WIDTH-1:0] mMem, mAlu;

  logic [VW-1:0] sb[$];
  logic [VW-1:0] exp;
  int checks   = 0;
  int failures = 0;

  writeback_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
    .wbs_in(wbs_in), .memData_in(memData_in), .ALUresult_in(ALUresult_in), .ni_in(ni_in),
    .wbs_out(wbs_out), .memData_out(memData_out), .ALUresult_out(ALUresult_out),
    .ni_out(ni_out), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDTH-1:0] modelWb();
    logic [WIDTH-1:0] sel;
    sel = mWbs ? mMem : mAlu;
`ifdef WB_BUBBLE_ZERO_EN
    if (!mNi) sel = '0;
`endif
    return sel;
  endfunction

  function automatic logic [VW-1:0] modelVec();
    return {mWbs, mNi, mMem, mAlu, modelWb()};
  endfunction

  function automatic logic [VW-1:0] dutVec();
    return {wbs_out, ni_out, memData_out, ALUresult_out, wb_data};
  endfunction

  // Drive one cycle of inputs, advance the model, push its expectation, then
  // settle just past the rising edge where outputs are sampled.
  task automatic step(input logic r, input logic st, input logic fl, input logic w,
                      input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] a, input logic n);
    rst_n = r; stall_in = st; flush_in = fl;
    wbs_in = w; memData_in = m; ALUresult_in = a; ni_in = n;
    if (!r || fl) begin
      mWbs = 1'b0; mNi = 1'b0; mMem = '0; mAlu = '0;
    end else if (!st) begin
      mWbs = w; mNi = n; mMem = m; mAlu = a;
    end
    sb.push_back(modelVec());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'h1234, 1'b1);
      exp = sb.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL reset_regs[%0d]: actual %h required %h", i, dutVec(), exp);
      end
    end
    checks++;
    if (wb_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_wb_data: actual %h required 0000", wb_data);
    end
  endtask

  task automatic test_alu_writeback();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h00FF, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL alu_regs: actual %h required %h", dutVec(), exp);
    end
    checks++;
    if (wb_data !== 16'h00FF || ni_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL alu_wb_data: actual %h/ni=%b required 00ff/ni=1", wb_data, ni_out);
    end
  endtask

  task automatic test_mem_writeback();
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0001, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL mem_regs: actual %h required %h", dutVec(), exp);
    end
    checks++;
    if (wb_data !== 16'hBEEF || wbs_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mem_wb_data: actual %h/wbs=%b required beef/wbs=1", wb_data, wbs_out);
    end
    wbs_in = 1'b0; memData_in = 16'h0BAD; ALUresult_in = 16'hF00D; ni_in = 1'b0;
    #2;
    checks++;
    if (dutVec() !== modelVec()) begin
      failures++;
      $display("[TB] FAIL mem_hold_between_edges: actual %h required %h", dutVec(), modelVec());
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1111, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL stall_load: actual %h required %h", dutVec(), exp);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h2222, 1'b1);
      exp = sb.pop_front();
      checks++;
      if (dutVec() !== exp || wb_data !== 16'h1111) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: actual %h required %h", i, dutVec(), exp);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h2222, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp || wb_data !== 16'h2222) begin
      failures++;
      $display("[TB] FAIL stall_release: actual %h required %h", dutVec(), exp);
    end
  endtask

  task automatic test_flush_vs_stall();
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hC3C3, 16'h4444, 1'b1);
    void'(sb.pop_front());
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A, 16'h6666, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp || ni_out !== 1'b0 || wb_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL flush_over_stall: actual %h required %h", dutVec(), exp);
    end
  endtask

  task automatic test_bubble();
    logic [WIDTH-1:0] want;
`ifdef WB_BUBBLE_ZERO_EN
    want = 16'h0000;
`else
    want = 16'h7777;
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h7777, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp || wb_data !== want) begin
      failures++;
      $display("[TB] FAIL bubble_gating: actual %h required %h", dutVec(), exp);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h8888, 16'h7777, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp) begin
      failures++;
      $display("[TB] FAIL bubble_mem_path: actual %h required %h", dutVec(), exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      exp = sb.pop_front();
      checks++;
      if (dutVec() !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d]: actual %h required %h", i, dutVec(), exp);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hFACE, 16'h0F0F, 1'b1);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h1357, 16'h2468, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (dutVec() !== exp || ni_out !== 1'b0 || wb_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_over_stall: actual %h required %h", dutVec(), exp);
    end
  endtask

  initial begin
    mWbs = 1'b0; mNi = 1'b0; mMem = '0; mAlu = '0;
    rst_n = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    wbs_in = 1'b0; ni_in = 1'b0; memData_in = '0; ALUresult_in = '0;
    test_reset();
    test_alu_writeback();
    test_mem_writeback();
    test_stall();
    test_flush_vs_stall();
    test_bubble();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
